// File: rtl/rc_pkg.sv
// Shared constants and types for the RC pulse-position-modulation blocks.
package rc_pkg;

  localparam int unsigned TICKS_PER_MS  = 255;
  localparam logic [7:0]  NEUTRAL_WIDTH = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    CH_MARK,
    CH_SPACE,
    END_MARK,
    SYNC_SPACE
  } ppm_state_t;

  // Full slot length in ticks: 1 ms base plus the channel width (255..510).
  function automatic logic [9:0] slot_len(input logic [7:0] w);
    return 10'(TICKS_PER_MS) + {2'b00, w};
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Loadable 10-bit down-counter; done_o marks the last cycle of a loaded interval.
module ppm_slot_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [9:0] load_val_i,
  output logic       done_o
);

  logic [9:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 10'd0) begin
      cnt_q <= cnt_q - 10'd1;
    end
  end

  // A load of N makes the interval last exactly N cycles.
  assign done_o = (cnt_q == 10'd1);

endmodule

// File: rtl/ppm_frame_encoder.sv
// Multi-channel RC PPM transmitter: NUM_CH slots of 1-2 ms plus a sync gap per frame.
//   state      | meaning
//   IDLE       | line idle, waiting for enable
//   CH_MARK    | mark pulse opening channel ch
//   CH_SPACE   | remainder of channel ch slot
//   END_MARK   | mark pulse closing the last channel
//   SYNC_SPACE | idle until the frame period expires
module ppm_frame_encoder
  import rc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned FRAME_TICKS = 5610,
  parameter int unsigned MARK_TICKS  = 77,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic                clk_255kHz_i,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic [NUM_CH*8-1:0] width_i,
  input  logic [NUM_CH-1:0]   width_valid_i,
  output logic                ppm_o,
  output logic                frame_start_o,
  output logic                busy_o,
  output logic [2:0]          ch_index_o
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("ppm_frame_encoder: NUM_CH must be 1..8");
  end
  if (MARK_TICKS == 0 || MARK_TICKS >= TICKS_PER_MS) begin : g_bad_mark
    $error("ppm_frame_encoder: MARK_TICKS must be 1..254");
  end
  if (FRAME_TICKS >= 8192 ||
      NUM_CH * 2 * TICKS_PER_MS + MARK_TICKS > FRAME_TICKS - TICKS_PER_MS) begin : g_bad_frame
    $error("ppm_frame_encoder: worst-case frame leaves less than 1 ms of sync");
  end

  ppm_state_t  state_q;
  logic [12:0] frame_cnt_q;
  logic [3:0]  ch_q;
  logic [7:0]  width_q [8];
  logic [7:0]  latch_d [8];
  logic        mark_q;
  logic        busy_q;
  logic        fs_q;

  logic        tmr_load;
  logic [9:0]  tmr_val;
  logic        tmr_done;
  logic        start_frame;
  logic        frame_last;
  logic        last_ch;
  logic [7:0]  cur_w;

  always_comb begin
    for (int n = 0; n < 8; n++) latch_d[n] = NEUTRAL_WIDTH;
    for (int n = 0; n < NUM_CH; n++) begin
      latch_d[n] = width_valid_i[n] ? width_i[8*n +: 8] : NEUTRAL_WIDTH;
    end
  end

  assign cur_w      = width_q[ch_q[2:0]];
  assign frame_last = (frame_cnt_q == 13'(FRAME_TICKS - 1));
  assign last_ch    = ((ch_q + 4'd1) == 4'(NUM_CH));

  // Timer loads coincide with the state transitions they time.
  always_comb begin
    tmr_load    = 1'b0;
    tmr_val     = 10'(MARK_TICKS);
    start_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_frame = enable_i;
        tmr_load    = enable_i;
      end
      CH_MARK: begin
        tmr_load = tmr_done;
        tmr_val  = slot_len(cur_w) - 10'(MARK_TICKS);
      end
      CH_SPACE: tmr_load = tmr_done;
      SYNC_SPACE: begin
        start_frame = frame_last && enable_i;
        tmr_load    = frame_last && enable_i;
      end
      default: ;
    endcase
  end

  ppm_slot_timer u_timer (
    .clk_i      (clk_255kHz_i),
    .rst_ni     (reset_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_255kHz_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      ch_q        <= '0;
      mark_q      <= 1'b0;
      busy_q      <= 1'b0;
      fs_q        <= 1'b0;
      for (int n = 0; n < 8; n++) width_q[n] <= '0;
    end else begin
      fs_q <= 1'b0;
      if (start_frame) begin
        width_q     <= latch_d;
        state_q     <= CH_MARK;
        frame_cnt_q <= '0;
        ch_q        <= '0;
        mark_q      <= 1'b1;
        busy_q      <= 1'b1;
        fs_q        <= 1'b1;
      end else begin
        if (busy_q) frame_cnt_q <= frame_cnt_q + 13'd1;
        unique case (state_q)
          CH_MARK: if (tmr_done) begin
            state_q <= CH_SPACE;
            mark_q  <= 1'b0;
          end
          CH_SPACE: if (tmr_done) begin
            ch_q    <= ch_q + 4'd1;
            state_q <= last_ch ? END_MARK : CH_MARK;
            mark_q  <= 1'b1;
          end
          END_MARK: if (tmr_done) begin
            state_q <= SYNC_SPACE;
            mark_q  <= 1'b0;
          end
          SYNC_SPACE: if (frame_last) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            ch_q        <= '0;
            frame_cnt_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            mark_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ppm_o         = ACTIVE_HIGH ? mark_q : ~mark_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;
  assign ch_index_o    = ch_q[2:0];

endmodule

// File: tb/tb_ppm_frame_encoder.sv
// Directed bench for ppm_frame_encoder: captures whole frames and measures slot timing.
module tb_ppm_frame_encoder;

  localparam int FT = 5610;
  localparam int MK = 77;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [47:0] width = '0;
  logic [5:0]  wv = '0;
  logic        ppm, fs, busy;
  logic [2:0]  ch_idx;

  int vectors = 0;
  int errors  = 0;

  bit       cap_ppm  [FT];
  bit       cap_fs   [FT];
  bit       cap_busy [FT];
  logic [2:0] cap_ch [FT];
  int rises[$];
  int mlen[$];

  ppm_frame_encoder #(.NUM_CH(6), .FRAME_TICKS(FT), .MARK_TICKS(MK), .ACTIVE_HIGH(1'b1)) dut (
    .clk_255kHz_i  (clk),
    .reset_ni      (rst_n),
    .enable_i      (en),
    .width_i       (width),
    .width_valid_i (wv),
    .ppm_o         (ppm),
    .frame_start_o (fs),
    .busy_o        (busy),
    .ch_index_o    (ch_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mkw(input logic [7:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic int slot(input int k);
    if (k + 1 < rises.size()) return rises[k+1] - rises[k];
    return -1;
  endfunction

  function automatic int sync_gap();
    if (rises.size() == 7 && mlen.size() == 7) return FT - (rises[6] + mlen[6]);
    return -1;
  endfunction

  function automatic int fs_count();
    int c = 0;
    for (int i = 0; i < FT; i++) if (cap_fs[i]) c++;
    return c;
  endfunction

  function automatic int bad_marks();
    int c = 0;
    foreach (mlen[k]) if (mlen[k] != MK) c++;
    return c;
  endfunction

  // Waits at most budget cycles for frame_start; waited = cycles taken.
  task automatic wait_fs(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      @(negedge clk);
      waited++;
      if (fs === 1'b1) ok = 1'b1;
    end
  endtask

  // Starts on the negedge of a frame's first cycle; ends on cycle FT (next frame's first).
  task automatic capture(input int chg_at, input logic [47:0] chg_w, input logic [5:0] chg_wv,
                         input logic chg_en);
    for (int i = 0; i < FT; i++) begin
      if (i == chg_at) begin
        width = chg_w;
        wv    = chg_wv;
        en    = chg_en;
      end
      cap_ppm[i]  = (ppm === 1'b1);
      cap_fs[i]   = (fs === 1'b1);
      cap_busy[i] = (busy === 1'b1);
      cap_ch[i]   = ch_idx;
      @(negedge clk);
    end
    rises.delete();
    mlen.delete();
    for (int i = 0; i < FT; i++) begin
      if (cap_ppm[i] && (i == 0 || !cap_ppm[i-1])) rises.push_back(i);
    end
    foreach (rises[k]) begin
      int j = rises[k];
      while (j < FT && cap_ppm[j]) j++;
      mlen.push_back(j - rises[k]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (ppm !== 1'b0) begin errors++; $display("FAIL reset_ppm: got %b expected 0", ppm); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", fs); end
    vectors++; if (ch_idx !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", ch_idx); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b0 || ppm !== 1'b0) begin
      errors++; $display("FAIL idle_disabled: got busy=%b ppm=%b expected 0/0", busy, ppm);
    end
  endtask

  task automatic test_neutral();
    bit ok;
    int waited;
    width = mkw(127, 127, 127, 127, 127, 127);
    wv = 6'b111111;
    en = 1'b1;
    wait_fs(4, ok, waited);
    vectors++; if (!ok || waited !== 1) begin
      errors++; $display("FAIL neutral_start_latency: got %0d cycles expected 1", waited);
    end
    for (int f = 0; f < 3; f++) begin
      capture(-1, width, wv, 1'b1);
      vectors++; if (rises.size() !== 7) begin
        errors++; $display("FAIL neutral_f%0d_marks: got %0d expected 7", f, rises.size());
      end
      for (int k = 0; k < 6; k++) begin
        vectors++; if (slot(k) !== 382) begin
          errors++; $display("FAIL neutral_f%0d_slot%0d: got %0d expected 382", f, k, slot(k));
        end
      end
      vectors++; if (bad_marks() !== 0 || mlen.size() !== 7) begin
        errors++; $display("FAIL neutral_f%0d_mark_len: got %0d bad expected 0", f, bad_marks());
      end
      vectors++; if (sync_gap() !== 3241) begin
        errors++; $display("FAIL neutral_f%0d_sync: got %0d expected 3241", f, sync_gap());
      end
      vectors++; if (fs_count() !== 1 || !cap_fs[0]) begin
        errors++; $display("FAIL neutral_f%0d_fs_count: got %0d expected 1", f, fs_count());
      end
      vectors++; if (!cap_busy[FT-1] || !cap_busy[0]) begin
        errors++; $display("FAIL neutral_f%0d_busy: got %b expected 1", f, cap_busy[FT-1]);
      end
      vectors++; if (cap_ch[0] !== 3'd0 || cap_ch[382] !== 3'd1 || cap_ch[2292] !== 3'd6 || cap_ch[5000] !== 3'd6) begin
        errors++; $display("FAIL neutral_f%0d_ch_index: got %0d/%0d/%0d/%0d expected 0/1/6/6",
                           f, cap_ch[0], cap_ch[382], cap_ch[2292], cap_ch[5000]);
      end
      vectors++; if (fs !== 1'b1) begin
        errors++; $display("FAIL neutral_f%0d_period: got fs=%b at tick %0d expected 1", f, fs, FT);
      end
    end
  endtask

  task automatic test_extremes();
    capture(3000, mkw(0, 255, 127, 127, 127, 127), 6'b111111, 1'b1);
    vectors++; if (slot(0) !== 382 || slot(1) !== 382) begin
      errors++; $display("FAIL ext_prev_frame: got %0d/%0d expected 382/382", slot(0), slot(1));
    end
    capture(-1, width, wv, 1'b1);
    vectors++; if (slot(0) !== 255) begin errors++; $display("FAIL ext_slot0: got %0d expected 255", slot(0)); end
    vectors++; if (slot(1) !== 510) begin errors++; $display("FAIL ext_slot1: got %0d expected 510", slot(1)); end
    vectors++; if (slot(5) !== 382) begin errors++; $display("FAIL ext_slot5: got %0d expected 382", slot(5)); end
    vectors++; if (sync_gap() !== 3240) begin errors++; $display("FAIL ext_sync: got %0d expected 3240", sync_gap()); end
    vectors++; if (fs !== 1'b1) begin errors++; $display("FAIL ext_period: got fs=%b expected 1", fs); end
  endtask

  task automatic test_invalid();
    capture(3000, mkw(127, 127, 200, 200, 127, 127), 6'b111011, 1'b1);
    capture(-1, width, wv, 1'b1);
    vectors++; if (slot(2) !== 382) begin errors++; $display("FAIL inv_slot2_neutral: got %0d expected 382", slot(2)); end
    vectors++; if (slot(3) !== 455) begin errors++; $display("FAIL inv_slot3_valid: got %0d expected 455", slot(3)); end
    vectors++; if (slot(1) !== 382) begin errors++; $display("FAIL inv_slot1: got %0d expected 382", slot(1)); end
  endtask

  task automatic test_midframe_change();
    capture(3000, mkw(0, 127, 127, 127, 127, 127), 6'b111111, 1'b1);
    capture(1100, mkw(255, 127, 127, 127, 127, 0), 6'b111111, 1'b1);
    vectors++; if (slot(0) !== 255) begin errors++; $display("FAIL mid_cur_slot0: got %0d expected 255", slot(0)); end
    vectors++; if (slot(5) !== 382) begin errors++; $display("FAIL mid_cur_slot5: got %0d expected 382", slot(5)); end
    capture(-1, width, wv, 1'b1);
    vectors++; if (slot(0) !== 510) begin errors++; $display("FAIL mid_next_slot0: got %0d expected 510", slot(0)); end
    vectors++; if (slot(5) !== 255) begin errors++; $display("FAIL mid_next_slot5: got %0d expected 255", slot(5)); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int waited;
    int stray = 0;
    capture(600, width, wv, 1'b0);
    vectors++; if (rises.size() !== 7 || slot(0) !== 510 || slot(5) !== 255) begin
      errors++; $display("FAIL drop_frame_complete: got marks=%0d slot0=%0d slot5=%0d expected 7/510/255",
                         rises.size(), slot(0), slot(5));
    end
    vectors++; if (!cap_busy[FT-1]) begin errors++; $display("FAIL drop_busy_last: got 0 expected 1"); end
    vectors++; if (busy !== 1'b0 || ppm !== 1'b0 || fs !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got busy=%b ppm=%b fs=%b expected 0/0/0", busy, ppm, fs);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fs !== 1'b0 || ppm !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++; if (stray !== 0) begin errors++; $display("FAIL drop_stays_idle: got %0d active cycles expected 0", stray); end
    en = 1'b1;
    wait_fs(4, ok, waited);
    vectors++; if (!ok || waited !== 1) begin
      errors++; $display("FAIL reenable_latency: got %0d cycles expected 1", waited);
    end
  endtask

  task automatic test_reset_mid_mark();
    bit ok;
    int waited;
    repeat (902) @(negedge clk);
    vectors++; if (ch_idx !== 3'd2 || ppm !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got ch=%0d ppm=%b expected 2/1", ch_idx, ppm);
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (ppm !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: got ppm=%b busy=%b expected 0/0", ppm, busy);
    end
    vectors++; if (ch_idx !== 3'd0 || fs !== 1'b0) begin
      errors++; $display("FAIL rst_async_ch: got ch=%0d fs=%b expected 0/0", ch_idx, fs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(4, ok, waited);
    vectors++; if (!ok || waited !== 1 || ch_idx !== 3'd0 || ppm !== 1'b1) begin
      errors++; $display("FAIL rst_restart: got wait=%0d ch=%0d ppm=%b expected 1/0/1", waited, ch_idx, ppm);
    end
    capture(-1, width, wv, 1'b1);
    vectors++; if (rises.size() !== 7 || slot(0) !== 510) begin
      errors++; $display("FAIL rst_restart_frame: got marks=%0d slot0=%0d expected 7/510", rises.size(), slot(0));
    end
  endtask

  initial begin
    test_reset();
    test_neutral();
    test_extremes();
    test_invalid();
    test_midframe_change();
    test_enable_drop();
    test_reset_mid_mark();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
